// File: rtl/snake_body_stream.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_stream
// Description : Snake game body store and segment streamer. The body is kept
//               as a head coordinate plus a chain of per-segment directions
//               (dir_mem). Segments are replayed continuously, one per clock,
//               by walking the chain from the head with a running accumulator.
//               Between passes a one-cycle GAP decides whether a pending move
//               is applied in a one-cycle MOVE slot.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   1  clock
//   rst_n         in   1  asynchronous active-low reset
//   game_rst_n    in   1  synchronous active-low game restart
//   tick          in   1  move-request pulse (merged until applied)
//   grow          in   1  grow-request pulse (merged until applied)
//   turn_valid    in   1  heading request strobe
//   turn_dir      in   2  requested heading (0:+y 1:-y 2:+x 3:-x)
//   snake_head_x  out  5  current head column
//   snake_head_y  out  4  current head row
//   snake_x       out  5  streamed segment column
//   snake_y       out  4  streamed segment row
//   snake_dir     out  2  direction from streamed segment toward the next one
//   snake_first   out  1  streamed segment is the head
//   snake_last    out  1  streamed segment is the tail
//   snake_valid   out  1  stream outputs carry a segment this cycle
//   length        out  6  body length in segments
//   failure       out  1  sticky: wall hit or self collision
//   success       out  1  sticky: body reached MAX_LEN
// ============================================================================
module snake_body_stream #(
  parameter int GAME_WIDTH  = 18,
  parameter int GAME_HEIGHT = 13,
  parameter int MAX_LEN     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_rst_n,
  input  logic       tick,
  input  logic       grow,
  input  logic       turn_valid,
  input  logic [1:0] turn_dir,
  output logic [4:0] snake_head_x,
  output logic [3:0] snake_head_y,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic [1:0] snake_dir,
  output logic       snake_first,
  output logic       snake_last,
  output logic       snake_valid,
  output logic [5:0] length,
  output logic       failure,
  output logic       success
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [4:0] c_start_x   = 5'd4;
  localparam logic [3:0] c_start_y   = 4'd7;
  localparam logic [1:0] c_start_dir = 2'd2;
  localparam logic [5:0] c_start_len = 6'd3;
  localparam logic [1:0] c_body_dir  = 2'd3;
  localparam logic [4:0] c_x_hi      = 5'(GAME_WIDTH + 1);
  localparam logic [3:0] c_y_hi      = 4'(GAME_HEIGHT + 1);
  localparam logic [5:0] c_max_len   = 6'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_GAP    = 2'd1,
    ST_MOVE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [4:0]      r_acc_x;
  logic [3:0]      r_acc_y;
  logic [4:0]      r_head_x;
  logic [3:0]      r_head_y;
  logic [1:0]      r_heading;
  logic            r_move_pend;
  logic            r_grow_pend;
  logic            r_hit;
  logic [1:0]      r_dir_mem [MAX_LEN];

  logic [1:0]      w_seg_dir;
  logic [4:0]      w_acc_nx;
  logic [3:0]      w_acc_ny;
  logic [4:0]      w_new_x;
  logic [3:0]      w_new_y;
  logic            w_last;
  logic            w_hit_now;
  logic            w_out;
  logic            w_turn_ok;
  logic            w_grow_ok;
  logic [1:0]      w_back_dir;

  assign snake_head_x = r_head_x;
  assign snake_head_y = r_head_y;

  assign w_seg_dir  = r_dir_mem[r_idx];
  assign w_last     = (6'(r_idx) == (length - 6'd1));
  // Segment 0 is the head itself; only later segments can collide with it.
  assign w_hit_now  = (r_idx != '0) && (r_acc_x == r_head_x) && (r_acc_y == r_head_y);
  assign w_out      = (w_new_x == 5'd0) || (w_new_x == c_x_hi) ||
                      (w_new_y == 4'd0) || (w_new_y == c_y_hi);
  // A reversal would drive the head straight into segment 1, so it is refused.
  assign w_turn_ok  = turn_valid && (turn_dir != {r_heading[1], ~r_heading[0]});
  assign w_grow_ok  = r_grow_pend && (length < c_max_len);
  // The old head becomes segment 1, which lies opposite to the heading taken.
  assign w_back_dir = {r_heading[1], ~r_heading[0]};

  // Unit steps: accumulator walk along the body and head advance.
  always_comb begin
    w_acc_nx = r_acc_x;
    w_acc_ny = r_acc_y;
    case (w_seg_dir)
      2'd0:    w_acc_ny = r_acc_y + 4'd1;
      2'd1:    w_acc_ny = r_acc_y - 4'd1;
      2'd2:    w_acc_nx = r_acc_x + 5'd1;
      default: w_acc_nx = r_acc_x - 5'd1;
    endcase
    w_new_x = r_head_x;
    w_new_y = r_head_y;
    case (r_heading)
      2'd0:    w_new_y = r_head_y + 4'd1;
      2'd1:    w_new_y = r_head_y - 4'd1;
      2'd2:    w_new_x = r_head_x + 5'd1;
      default: w_new_x = r_head_x - 5'd1;
    endcase
  end

  // Direction chain: shifts toward the tail on every successful move. Entries
  // beyond the current length are don't-care and simply fall off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LEN; k++) r_dir_mem[k] <= c_body_dir;
    end else if (!game_rst_n) begin
      for (int k = 0; k < MAX_LEN; k++) r_dir_mem[k] <= c_body_dir;
    end else if ((r_state == ST_MOVE) && !w_out) begin
      for (int k = MAX_LEN - 1; k > 0; k--) r_dir_mem[k] <= r_dir_mem[k-1];
      r_dir_mem[0] <= w_back_dir;
    end
  end

  // Control FSM, game state and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_STREAM;
      r_idx       <= '0;
      r_acc_x     <= c_start_x;
      r_acc_y     <= c_start_y;
      r_head_x    <= c_start_x;
      r_head_y    <= c_start_y;
      r_heading   <= c_start_dir;
      r_move_pend <= 1'b0;
      r_grow_pend <= 1'b0;
      r_hit       <= 1'b0;
      length      <= c_start_len;
      failure     <= 1'b0;
      success     <= 1'b0;
      snake_x     <= '0;
      snake_y     <= '0;
      snake_dir   <= '0;
      snake_first <= 1'b0;
      snake_last  <= 1'b0;
      snake_valid <= 1'b0;
    end else if (!game_rst_n) begin
      r_state     <= ST_STREAM;
      r_idx       <= '0;
      r_acc_x     <= c_start_x;
      r_acc_y     <= c_start_y;
      r_head_x    <= c_start_x;
      r_head_y    <= c_start_y;
      r_heading   <= c_start_dir;
      r_move_pend <= 1'b0;
      r_grow_pend <= 1'b0;
      r_hit       <= 1'b0;
      length      <= c_start_len;
      failure     <= 1'b0;
      success     <= 1'b0;
      snake_x     <= '0;
      snake_y     <= '0;
      snake_dir   <= '0;
      snake_first <= 1'b0;
      snake_last  <= 1'b0;
      snake_valid <= 1'b0;
    end else begin
      if (w_turn_ok) r_heading <= turn_dir;
      if (tick)      r_move_pend <= 1'b1;
      if (grow)      r_grow_pend <= 1'b1;

      case (r_state)
        ST_STREAM: begin
          snake_x     <= r_acc_x;
          snake_y     <= r_acc_y;
          snake_dir   <= w_seg_dir;
          snake_first <= (r_idx == '0);
          snake_last  <= w_last;
          snake_valid <= 1'b1;
          r_acc_x     <= w_acc_nx;
          r_acc_y     <= w_acc_ny;
          if (w_last) begin
            // Collision is reported only once the whole body has been seen.
            failure <= failure | r_hit | w_hit_now;
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_hit <= r_hit | w_hit_now;
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_GAP: begin
          snake_valid <= 1'b0;
          snake_first <= 1'b0;
          snake_last  <= 1'b0;
          r_acc_x     <= r_head_x;
          r_acc_y     <= r_head_y;
          if (r_move_pend && !failure && !success) r_state <= ST_MOVE;
          else                                     r_state <= ST_STREAM;
        end

        ST_MOVE: begin
          snake_valid <= 1'b0;
          snake_first <= 1'b0;
          snake_last  <= 1'b0;
          // A pulse landing in this very cycle belongs to the next move.
          r_move_pend <= tick;
          r_grow_pend <= grow;
          if (w_out) begin
            failure <= 1'b1;
            r_acc_x <= r_head_x;
            r_acc_y <= r_head_y;
          end else begin
            r_head_x <= w_new_x;
            r_head_y <= w_new_y;
            r_acc_x  <= w_new_x;
            r_acc_y  <= w_new_y;
            if (w_grow_ok) begin
              length <= length + 6'd1;
              if ((length + 6'd1) == c_max_len) success <= 1'b1;
            end
          end
          r_state <= ST_STREAM;
        end

        default: begin
          r_state <= ST_STREAM;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_body_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_body_stream
// Description : Directed self-checking bench for snake_body_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_body_stream;

  logic       clk = 1'b0;
  logic       rst_n, game_rst_n, tick, grow, turn_valid;
  logic [1:0] turn_dir;
  logic [4:0] snake_head_x, snake_x;
  logic [3:0] snake_head_y, snake_y;
  logic [1:0] snake_dir;
  logic       snake_first, snake_last, snake_valid, failure, success;
  logic [5:0] length;

  int checks = 0;
  int errors = 0;

  logic [4:0] cap_x [64];
  logic [3:0] cap_y [64];
  logic [1:0] cap_d [64];
  int         cap_n;
  logic       cap_fail_first;
  logic       cap_fail_last;

  always #5 clk = ~clk;

  snake_body_stream #(.GAME_WIDTH(18), .GAME_HEIGHT(13), .MAX_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n), .tick(tick), .grow(grow),
    .turn_valid(turn_valid), .turn_dir(turn_dir),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .snake_x(snake_x), .snake_y(snake_y), .snake_dir(snake_dir),
    .snake_first(snake_first), .snake_last(snake_last), .snake_valid(snake_valid),
    .length(length), .failure(failure), .success(success)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares {x,y,dir} of a captured segment.
  task automatic chk_seg(input string tag, input int i, input logic [4:0] ex,
                         input logic [3:0] ey, input logic [1:0] ed);
    chk(tag, {21'd0, cap_x[i], cap_y[i], cap_d[i]}, {21'd0, ex, ey, ed});
  endtask

  task automatic wait_first();
    int n = 0;
    while (!(snake_valid === 1'b1 && snake_first === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100) else begin
      errors++;
      $error("FAIL wait_first: observed timeout after %0d cycles expected first segment", n);
    end
  endtask

  task automatic capture_pass();
    int n = 0;
    wait_first();
    cap_n = 0;
    cap_fail_first = failure;
    cap_fail_last  = failure;
    while (n < 70) begin
      cap_x[cap_n] = snake_x;
      cap_y[cap_n] = snake_y;
      cap_d[cap_n] = snake_dir;
      cap_n++;
      if (snake_last === 1'b1) begin
        cap_fail_last = failure;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Request pulses are issued while a pass is in flight so the following GAP
  // sees them and the next captured pass shows the moved body.
  task automatic do_tick(input logic g, input logic tv, input logic [1:0] td);
    wait_first();
    tick = 1'b1; grow = g; turn_valid = tv; turn_dir = td;
    @(negedge clk);
    tick = 1'b0; grow = 1'b0; turn_valid = 1'b0; turn_dir = 2'd0;
  endtask

  task automatic restart();
    @(negedge clk);
    game_rst_n = 1'b0;
    @(negedge clk);
    game_rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; game_rst_n = 1'b1; tick = 1'b0; grow = 1'b0;
    turn_valid = 1'b0; turn_dir = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", {31'd0, snake_valid}, 32'd0);
    chk("rst_x", {27'd0, snake_x}, 32'd0);
    chk("rst_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd4, 4'd7});
    chk("rst_len", {26'd0, length}, 32'd3);
    chk("rst_flags", {30'd0, failure, success}, 32'd0);

    // First pass, cycle exact
    rst_n = 1'b1;
    @(negedge clk);
    chk("p0_seg0", {19'd0, snake_x, snake_y, snake_dir, snake_first, snake_last},
        {19'd0, 5'd4, 4'd7, 2'd3, 1'b1, 1'b0});
    chk("p0_v0", {31'd0, snake_valid}, 32'd1);
    @(negedge clk);
    chk("p0_seg1", {19'd0, snake_x, snake_y, snake_dir, snake_first, snake_last},
        {19'd0, 5'd3, 4'd7, 2'd3, 1'b0, 1'b0});
    @(negedge clk);
    chk("p0_seg2", {19'd0, snake_x, snake_y, snake_dir, snake_first, snake_last},
        {19'd0, 5'd2, 4'd7, 2'd3, 1'b0, 1'b1});
    @(negedge clk);
    chk("p0_gap", {31'd0, snake_valid}, 32'd0);
    @(negedge clk);
    chk("p1_first", {30'd0, snake_valid, snake_first}, 32'd3);

    // Plain tick
    do_tick(1'b0, 1'b0, 2'd0);
    capture_pass();
    chk("tick_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd5, 4'd7});
    chk("tick_n", cap_n, 3);
    chk_seg("tick_s0", 0, 5'd5, 4'd7, 2'd3);
    chk_seg("tick_s1", 1, 5'd4, 4'd7, 2'd3);
    chk_seg("tick_s2", 2, 5'd3, 4'd7, 2'd3);
    chk("tick_len", {26'd0, length}, 32'd3);

    // Grow + tick from a fresh game
    restart();
    do_tick(1'b1, 1'b0, 2'd0);
    capture_pass();
    chk("grow_len", {26'd0, length}, 32'd4);
    chk("grow_n", cap_n, 4);
    chk_seg("grow_s0", 0, 5'd5, 4'd7, 2'd3);
    chk_seg("grow_s3", 3, 5'd2, 4'd7, 2'd3);

    // Reverse request is ignored
    restart();
    do_tick(1'b0, 1'b1, 2'd3);
    capture_pass();
    chk("rev_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd5, 4'd7});

    // Turn to -y
    restart();
    do_tick(1'b0, 1'b1, 2'd1);
    capture_pass();
    chk("turn_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd4, 4'd6});
    chk_seg("turn_s0", 0, 5'd4, 4'd6, 2'd0);
    chk_seg("turn_s1", 1, 5'd4, 4'd7, 2'd3);
    chk_seg("turn_s2", 2, 5'd3, 4'd7, 2'd3);

    // Wall at x = GAME_WIDTH + 1
    restart();
    for (int k = 0; k < 14; k++) begin
      do_tick(1'b0, 1'b0, 2'd0);
      capture_pass();
    end
    chk("wall_pre_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd18, 4'd7});
    chk("wall_pre_fail", {31'd0, failure}, 32'd0);
    do_tick(1'b0, 1'b0, 2'd0);
    capture_pass();
    chk("wall_fail", {31'd0, failure}, 32'd1);
    chk("wall_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd18, 4'd7});
    do_tick(1'b0, 1'b0, 2'd0);
    capture_pass();
    chk("wall_nomove", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd18, 4'd7});
    chk("wall_stream_n", cap_n, 3);
    chk_seg("wall_s2", 2, 5'd16, 4'd7, 2'd3);

    // Self collision with a length-5 body
    restart();
    do_tick(1'b1, 1'b0, 2'd0);
    capture_pass();
    do_tick(1'b1, 1'b0, 2'd0);
    capture_pass();
    chk("loop_len", {26'd0, length}, 32'd5);
    do_tick(1'b0, 1'b1, 2'd0);
    capture_pass();
    do_tick(1'b0, 1'b1, 2'd3);
    capture_pass();
    chk("loop_mid_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd5, 4'd8});
    do_tick(1'b0, 1'b1, 2'd1);
    capture_pass();
    chk("loop_head", {23'd0, snake_head_x, snake_head_y}, {23'd0, 5'd5, 4'd7});
    chk_seg("loop_s0", 0, 5'd5, 4'd7, 2'd0);
    chk_seg("loop_s1", 1, 5'd5, 4'd8, 2'd2);
    chk_seg("loop_s2", 2, 5'd6, 4'd8, 2'd1);
    chk_seg("loop_s4", 4, 5'd5, 4'd7, 2'd3);
    chk("loop_fail_at_first", {31'd0, cap_fail_first}, 32'd0);
    chk("loop_fail_at_end", {31'd0, cap_fail_last}, 32'd1);

    // Restart in the middle of a pass
    wait_first();
    @(negedge clk);
    game_rst_n = 1'b0;
    @(negedge clk);
    chk("grst_out", {20'd0, snake_x, snake_y, snake_valid, snake_first, snake_last},
        32'd0);
    chk("grst_state", {14'd0, snake_head_x, snake_head_y, length, failure, success},
        {14'd0, 5'd4, 4'd7, 6'd3, 1'b0, 1'b0});
    game_rst_n = 1'b1;
    @(negedge clk);
    chk("grst_seg0", {20'd0, snake_x, snake_y, snake_valid, snake_first, snake_last},
        {20'd0, 5'd4, 4'd7, 1'b1, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_body_stream.md
SNAKE_BODY_STREAM -- requirements
Module: snake_body_stream

Interface
REQ-001 SHALL have parameter GAME_WIDTH, default 18, meaning playfield columns 1..GAME_WIDTH.
REQ-002 SHALL have parameter GAME_HEIGHT, default 13, meaning playfield rows 1..GAME_HEIGHT.
REQ-003 SHALL have parameter MAX_LEN, default 32, meaning body capacity in segments.
REQ-004 SHALL use one clock and an asynchronous active-low reset; ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-005 SHALL have port game_rst_n, input, 1 bit: synchronous active-low game restart.
REQ-006 SHALL have port tick, input, 1 bit: move-request pulse.
REQ-007 SHALL have port grow, input, 1 bit: grow-request pulse.
REQ-008 SHALL have ports turn_valid (input, 1 bit) and turn_dir (input, 2 bits): requested heading.
REQ-009 SHALL have ports snake_head_x (output, 5 bits) and snake_head_y (output, 4 bits): head tile.
REQ-010 SHALL have ports snake_x (output, 5), snake_y (output, 4), snake_dir (output, 2), snake_first (output, 1), snake_last (output, 1), snake_valid (output, 1): segment stream.
REQ-011 SHALL have ports length (output, 6 bits), failure (output, 1 bit), success (output, 1 bit).

Function
REQ-012 Direction codes SHALL be: 0 = +y, 1 = -y, 2 = +x, 3 = -x; opposite(d) = {d[1], ~d[0]}.
REQ-013 SHALL store dir_mem[0..MAX_LEN-1]; entry i = direction from segment i toward segment i+1; segment 0 = head.
REQ-014 FSM SHALL have states STREAM, GAP, MOVE.
- STREAM: one segment per cycle, index i = 0..length-1; then GAP.
- GAP: one cycle, snake_valid=0; then MOVE if a move is pending and failure=success=0, else STREAM.
- MOVE: one cycle, snake_valid=0; then STREAM.
REQ-015 In STREAM, outputs SHALL be registered, one cycle after index i is selected.
- snake_x/snake_y = segment i coordinate; snake_dir = dir_mem[i].
- snake_first = (i==0); snake_last = (i==length-1); snake_valid=1.
REQ-016 Segment i+1 coordinate SHALL equal segment i coordinate plus the unit step of dir_mem[i], using a running accumulator seeded with the head.
REQ-017 tick SHALL set move_pending; grow SHALL set grow_pending; both are cleared only in MOVE; repeated pulses before MOVE SHALL merge.
REQ-018 turn_valid SHALL latch heading <= turn_dir unless turn_dir == opposite(heading), in which case it is ignored; the last accepted turn before MOVE wins.
REQ-019 In MOVE, new head = head + step(heading) (computed arithmetic, not a wrap).
- Out of range (x 0 or GAME_WIDTH+1, y 0 or GAME_HEIGHT+1): failure <= 1; head, dir_mem and length unchanged.
- Otherwise: dir_mem shifts up by one; dir_mem[0] <= opposite(heading); head updated.
REQ-020 In MOVE, if grow_pending and length < MAX_LEN, length SHALL increment; otherwise length is unchanged (tail dropped).
REQ-021 success SHALL set when length reaches MAX_LEN.
REQ-022 During STREAM, any segment with i>=1 equal to the head SHALL set failure at the end of that pass.
REQ-023 failure and success SHALL be sticky until reset or restart.
REQ-024 While failure or success is set, streaming SHALL continue; MOVE is never entered and pending requests are held.
REQ-025 snake_head_x/snake_head_y SHALL always reflect the current head register.

Reset
REQ-026 rst_n low SHALL asynchronously set, and game_rst_n low SHALL synchronously set:
- head (4,7), heading 2, length 3, dir_mem[0..] = 3.
- failure=0, success=0, pendings cleared.
- state STREAM at i=0, all stream outputs 0.
REQ-027 A game restart SHALL abort a pass mid-stream; the next cycle starts a fresh pass from i=0.

Verification
REQ-028 Reset release -> first pass (4,7,d3,first), (3,7,d3), (2,7,d3,last); then one GAP cycle with valid=0.
REQ-029 tick after reset -> after MOVE, head=(5,7), segments (5,7),(4,7),(3,7), length=3.
REQ-030 grow+tick -> length=4, segments (5,7),(4,7),(3,7),(2,7).
REQ-031 turn_dir=3 while heading=2 -> ignored; turn_dir=1 then tick -> head=(4,6), dir_mem[0]=0.
REQ-032 Head at x=18, heading 2, tick -> failure=1, head stays (18,y), later ticks cause no move, stream continues.
REQ-033 Length 5 loop: turns 0, 3, 1 on successive ticks -> head meets body -> failure=1 at end of pass; game_rst_n pulse mid-pass -> reset state, i=0 next cycle.
